// File: rtl/box_plotter_pkg.sv
// Shared types and defaults for the box plotter: FSM states, screen defaults
// and the scan-counter width helper.
package box_plotter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    DONE
  } state_e;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_COLOUR_W = 3;

  // A one-pixel dimension still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/box_scan_counter.sv
// Raster counter for one box: col is fastest, row advances on col wrap.
// last flags the final pixel of the box in the current cycle.
module box_scan_counter
  import box_plotter_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4,
  parameter int CW    = cnt_w(BOX_W),
  parameter int RW    = cnt_w(BOX_H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(BOX_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(BOX_H - 1);

  logic col_end;

  assign col_end = (col == COL_MAX);
  assign last    = col_end && (row == ROW_MAX);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/box_plotter.sv
// Box plotter: optionally erases the previous box, then draws a BOX_W x BOX_H
// box one pixel per clock with screen clipping. Erase built with BOX_PLOTTER_ERASE_EN.
module box_plotter
  import box_plotter_pkg::*;
#(
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
  input  logic [X_W-1:0]      iX,
  input  logic [Y_W-1:0]      iY,
  input  logic [COLOUR_W-1:0] iColour,
  input  logic [COLOUR_W-1:0] iBgColour,
  output logic [X_W-1:0]      oX,
  output logic [Y_W-1:0]      oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                oBusy,
  output logic                oDone
);

  localparam int CW = cnt_w(BOX_W);
  localparam int RW = cnt_w(BOX_H);
  localparam logic [X_W:0] SCR_W = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W + 1)'(SCREEN_H);

  state_e              state;
  logic [X_W-1:0]      new_x;
  logic [Y_W-1:0]      new_y;
  logic [COLOUR_W-1:0] new_colour;
  logic                draw_tail;

`ifdef BOX_PLOTTER_ERASE_EN
  logic [X_W-1:0]      old_x;
  logic [Y_W-1:0]      old_y;
  logic                old_valid;
  logic [COLOUR_W-1:0] bg_colour;
`else
  logic unused_bg;
  assign unused_bg = ^iBgColour;
`endif

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic                scan_last;
  logic                scan_clear;
  logic                phase_on;
  logic [X_W-1:0]      base_x;
  logic [Y_W-1:0]      base_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic [X_W:0]        px;
  logic [Y_W:0]        py;
  logic                in_screen;

  // Select the box being scanned; the DRAW tail cycle emits nothing so that
  // oDone lands one cycle after the last pixel leaves the output register.
  always_comb begin
    base_x     = new_x;
    base_y     = new_y;
    pix_colour = new_colour;
    phase_on   = 1'b0;
    case (state)
`ifdef BOX_PLOTTER_ERASE_EN
      ERASE: begin
        base_x     = old_x;
        base_y     = old_y;
        pix_colour = bg_colour;
        phase_on   = 1'b1;
      end
`endif
      DRAW:    phase_on = !draw_tail;
      default: phase_on = 1'b0;
    endcase
  end

  assign scan_clear = !phase_on || (state == ERASE && scan_last);

  box_scan_counter #(
    .BOX_W(BOX_W),
    .BOX_H(BOX_H),
    .CW   (CW),
    .RW   (RW)
  ) u_scan (
    .clock(iClock),
    .reset(iReset),
    .clear(scan_clear),
    .en   (phase_on),
    .col  (col),
    .row  (row),
    .last (scan_last)
  );

  // One extra bit so a box straddling the edge cannot wrap back on screen.
  assign px        = {1'b0, base_x} + (X_W + 1)'(col);
  assign py        = {1'b0, base_y} + (Y_W + 1)'(row);
  assign in_screen = (px < SCR_W) && (py < SCR_H);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state      <= IDLE;
      new_x      <= '0;
      new_y      <= '0;
      new_colour <= '0;
      draw_tail  <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oColour    <= '0;
      oPlot      <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
`ifdef BOX_PLOTTER_ERASE_EN
      old_x      <= '0;
      old_y      <= '0;
      old_valid  <= 1'b0;
      bg_colour  <= '0;
`endif
    end else begin
      oPlot <= phase_on && in_screen;
      oDone <= 1'b0;
      if (phase_on) begin
        oX      <= px[X_W-1:0];
        oY      <= py[Y_W-1:0];
        oColour <= pix_colour;
      end
      case (state)
        IDLE: begin
          if (iStart) begin
            new_x      <= iX;
            new_y      <= iY;
            new_colour <= iColour;
            oBusy      <= 1'b1;
`ifdef BOX_PLOTTER_ERASE_EN
            bg_colour  <= iBgColour;
            state      <= old_valid ? ERASE : DRAW;
`else
            state      <= DRAW;
`endif
          end
        end
        ERASE: begin
          if (scan_last) state <= DRAW;
        end
        DRAW: begin
          if (draw_tail) begin
            draw_tail <= 1'b0;
            oDone     <= 1'b1;
            state     <= DONE;
          end else if (scan_last) begin
            draw_tail <= 1'b1;
          end
        end
        DONE: begin
          oBusy     <= 1'b0;
          state     <= IDLE;
`ifdef BOX_PLOTTER_ERASE_EN
          old_x     <= new_x;
          old_y     <= new_y;
          old_valid <= 1'b1;
`endif
        end
        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
